cur_block_buffer: RTL

- Downstream neighbour of the reference-window SRAM stage. Fetches the 8x8 current (8-bit luma) block from frame memory when that stage pulses next_block.
- Holds the block in a shadow bank and promotes it to an active bank at the block boundary.
- Serves active rows, 64 bits = 8 pixels, to the SAD array alongside the 23-pixel reference rows.

---
 rtl/cur_block_buffer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cur_block_buffer.sv
// cur_block_buffer: fetches the 8x8 current luma block from frame memory.
// The block lands in a shadow bank. At the block boundary it is promoted to
// an active bank, which is served one 64-bit row at a time to the SAD array.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             global enable; all state holds while low
//   next_block     pulse: start fetching the next block
//   swap           pulse: promote shadow bank to active bank
//   cur_in         memory read data (8 pixels, MSB = leftmost)
//   row_sel        active-bank row to present on cur_out
//   cur_mem_addr   byte address of the current fetch beat (held when idle)
//   cur_rd_en      read strobe
//   cur_out        active-bank row row_sel (combinational)
//   cur_valid      active bank holds a valid block
//   load_busy      fetch or drain in progress
//   overrun        sticky: next_block while a block was outstanding
//   underrun       sticky: swap while the shadow bank was not ready
//
// Optional build macro CUR_BUF_STATS_EN adds blk_count (good swaps, wraps)
// and miss_count (underrun events, saturates).

module cur_block_buffer #(
    parameter int unsigned BLOCKS_PER_LINE = 482,
    parameter int unsigned LINE_STRIDE     = 3856,
    parameter int unsigned FRAME_BASE      = 0,
    parameter int unsigned RD_LAT          = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        next_block,
    input  logic        swap,
    input  logic [63:0] cur_in,
    input  logic [2:0]  row_sel,
    output logic [31:0] cur_mem_addr,
    output logic        cur_rd_en,
    output logic [63:0] cur_out,
    output logic        cur_valid,
    output logic        load_busy,
    output logic        overrun,
    output logic        underrun
`ifdef CUR_BUF_STATS_EN
    ,
    output logic [15:0] blk_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned BxW = (BLOCKS_PER_LINE > 1) ? $clog2(BLOCKS_PER_LINE) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StReady} state_e;

    state_e         state_q, state_d;
    logic [2:0]     beat_q, beat_d;
    logic [BxW-1:0] bx_q, bx_d;
    logic [15:0]    by_q, by_d;
    logic [31:0]    addr_calc, addr_q;
    logic [63:0]    shadow_q [8];
    logic [63:0]    active_q [8];
    // Delay line matching memory latency: issue flag and row index per beat.
    logic           pipe_vld_q [RD_LAT];
    logic [2:0]     pipe_row_q [RD_LAT];
    logic           issue, cap, swap_ok, start;

    assign issue   = en && (state_q == StFetch);
    assign cap     = en && pipe_vld_q[RD_LAT-1];
    assign swap_ok = en && swap && (state_q == StReady);

    assign addr_calc = 32'(FRAME_BASE)
                     + 32'(by_q) * (32'(LINE_STRIDE) << 3)
                     + (32'(bx_q) << 3)
                     + 32'(beat_q) * 32'(LINE_STRIDE);

    assign cur_rd_en    = issue;
    assign cur_mem_addr = (state_q == StFetch) ? addr_calc : addr_q;
    assign load_busy    = (state_q == StFetch) || (state_q == StDrain);
    assign cur_out      = active_q[row_sel];

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        bx_d    = bx_q;
        by_d    = by_q;
        start   = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (next_block) start = 1'b1;
                end
                StFetch: begin
                    beat_d = beat_q + 3'd1;
                    if (beat_q == 3'd7) begin
                        state_d = StDrain;
                        if (bx_q == BxW'(BLOCKS_PER_LINE - 1)) begin
                            bx_d = '0;
                            by_d = by_q + 16'd1;
                        end else begin
                            bx_d = bx_q + BxW'(1);
                        end
                    end
                end
                StDrain: begin
                    // Row 7 is always the last beat to come back.
                    if (pipe_vld_q[RD_LAT-1] && (pipe_row_q[RD_LAT-1] == 3'd7)) begin
                        state_d = StReady;
                    end
                end
                StReady: begin
                    if (swap) begin
                        state_d = StIdle;
                        // Promotion and refetch share the edge; shadow is free.
                        if (next_block) start = 1'b1;
                    end
                end
            endcase
        end
        if (start) begin
            state_d = StFetch;
            beat_d  = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            addr_q    <= '0;
            cur_valid <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_row_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            if (issue) addr_q <= addr_calc;
            if (en) begin
                pipe_vld_q[0] <= issue;
                pipe_row_q[0] <= beat_q;
                for (int unsigned i = 1; i < RD_LAT; i++) begin
                    pipe_vld_q[i] <= pipe_vld_q[i-1];
                    pipe_row_q[i] <= pipe_row_q[i-1];
                end
            end
            if (cap) shadow_q[pipe_row_q[RD_LAT-1]] <= cur_in;
            if (en && swap) begin
                if (state_q == StReady) begin
                    for (int unsigned i = 0; i < 8; i++) active_q[i] <= shadow_q[i];
                    cur_valid <= 1'b1;
                end else begin
                    cur_valid <= 1'b0;
                    underrun  <= 1'b1;
                end
            end
            if (en && next_block && (state_q != StIdle) && !swap_ok) overrun <= 1'b1;
        end
    end

`ifdef CUR_BUF_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_count  <= '0;
            miss_count <= '0;
        end else if (en && swap) begin
            if (state_q == StReady) begin
                blk_count <= blk_count + 16'd1;
            end else if (miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
